// File: rtl/ex_hazard_controller.sv
// Execute-stage hazard controller: operand forwarding select, load-use stalls,
// taken-branch squashing and saturating stall/flush performance counters.
module ex_hazard_controller #(
    parameter int unsigned LOAD_STALL_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES      = 2,
    parameter int unsigned CNT_W             = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [3:0]       id_src1_i,
    input  logic [3:0]       id_src2_i,
    input  logic             id_use1_i,
    input  logic             id_use2_i,
    input  logic [3:0]       ex_reg_to_write_i,
    input  logic             ex_reg_we_i,
    input  logic             ex_is_load_i,
    input  logic [3:0]       mem_reg_to_write_i,
    input  logic             mem_reg_we_i,
    input  logic [3:0]       wb_reg_to_write_i,
    input  logic             wb_reg_we_i,
    input  logic             branch_taken_i,
    output logic [1:0]       fwd_sel1_o,
    output logic [1:0]       fwd_sel2_o,
    output logic             stall_fetch_o,
    output logic             stall_decode_o,
    output logic             flush_decode_o,
    output logic             flush_execute_o,
    output logic [CNT_W-1:0] stall_count_o,
    output logic [CNT_W-1:0] flush_count_o
);

    typedef enum logic [1:0] {StRun, StLstall, StBflush} state_e;

    localparam bit         LoadMulti   = LOAD_STALL_CYCLES > 1;
    localparam bit         FlushMulti  = FLUSH_CYCLES > 1;
    localparam logic [3:0] LoadReload  = LoadMulti ? 4'(LOAD_STALL_CYCLES - 2) : 4'd0;
    localparam logic [3:0] FlushReload = FlushMulti ? 4'(FLUSH_CYCLES - 2) : 4'd0;
    localparam logic [CNT_W-1:0] CntMax = '1;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_count_q, flush_count_q;

    logic ex_m1, ex_m2, mem_m1, mem_m2, wb_m1, wb_m2;
    logic load_haz, accept_br, branch_evt;

    // Register 0 is hardwired zero and never participates in a hazard.
    function automatic logic match(input logic rd, input logic [3:0] src,
                                   input logic [3:0] dst, input logic we);
        return rd && we && (src == dst) && (src != 4'd0);
    endfunction

    always_comb begin
        ex_m1  = match(id_use1_i, id_src1_i, ex_reg_to_write_i, ex_reg_we_i);
        ex_m2  = match(id_use2_i, id_src2_i, ex_reg_to_write_i, ex_reg_we_i);
        mem_m1 = match(id_use1_i, id_src1_i, mem_reg_to_write_i, mem_reg_we_i);
        mem_m2 = match(id_use2_i, id_src2_i, mem_reg_to_write_i, mem_reg_we_i);
        wb_m1  = match(id_use1_i, id_src1_i, wb_reg_to_write_i, wb_reg_we_i);
        wb_m2  = match(id_use2_i, id_src2_i, wb_reg_to_write_i, wb_reg_we_i);
        load_haz = ex_is_load_i && (ex_m1 || ex_m2);
    end

    // A load result is not available in EX, so an EX match on a load falls through.
    always_comb begin
        fwd_sel1_o = 2'b00;
        fwd_sel2_o = 2'b00;
        if (!reset_i) begin
            if (ex_m1 && !ex_is_load_i) fwd_sel1_o = 2'b01;
            else if (mem_m1)            fwd_sel1_o = 2'b10;
            else if (wb_m1)             fwd_sel1_o = 2'b11;
            if (ex_m2 && !ex_is_load_i) fwd_sel2_o = 2'b01;
            else if (mem_m2)            fwd_sel2_o = 2'b10;
            else if (wb_m2)             fwd_sel2_o = 2'b11;
        end
    end

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        stall_fetch_o   = 1'b0;
        stall_decode_o  = 1'b0;
        flush_decode_o  = 1'b0;
        flush_execute_o = 1'b0;
        branch_evt      = 1'b0;
        // A branch seen while squashing comes from a wrong-path instruction.
        accept_br       = branch_taken_i && (state_q != StBflush);

        if (accept_br) begin
            flush_decode_o  = 1'b1;
            flush_execute_o = 1'b1;
            branch_evt      = 1'b1;
            if (FlushMulti) begin
                state_d = StBflush;
                cnt_d   = FlushReload;
            end else begin
                state_d = StRun;
            end
        end else begin
            unique case (state_q)
                StRun: begin
                    if (load_haz) begin
                        stall_fetch_o   = 1'b1;
                        stall_decode_o  = 1'b1;
                        flush_execute_o = 1'b1;
                        if (LoadMulti) begin
                            state_d = StLstall;
                            cnt_d   = LoadReload;
                        end
                    end
                end
                StLstall: begin
                    stall_fetch_o   = 1'b1;
                    stall_decode_o  = 1'b1;
                    flush_execute_o = 1'b1;
                    if (cnt_q == 4'd0) state_d = StRun;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                StBflush: begin
                    flush_decode_o  = 1'b1;
                    flush_execute_o = 1'b1;
                    if (cnt_q == 4'd0) state_d = StRun;
                    else               cnt_d   = cnt_q - 4'd1;
                end
                default: state_d = StRun;
            endcase
        end

        if (reset_i) begin
            stall_fetch_o   = 1'b0;
            stall_decode_o  = 1'b0;
            flush_decode_o  = 1'b0;
            flush_execute_o = 1'b0;
            branch_evt      = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= StRun;
            cnt_q         <= 4'd0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall_decode_o && (stall_count_q != CntMax)) begin
                stall_count_q <= stall_count_q + 1'b1;
            end
            if (branch_evt && (flush_count_q != CntMax)) begin
                flush_count_q <= flush_count_q + 1'b1;
            end
        end
    end

    assign stall_count_o = stall_count_q;
    assign flush_count_o = flush_count_q;

endmodule

// File: tb/tb_ex_hazard_controller.sv
// Bench for ex_hazard_controller: two parameterisations driven in lockstep and
// checked against a remaining-cycles reference model, vector table and directed cases.
module tb_ex_hazard_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] src1, src2, ex_dst, mem_dst, wb_dst;
    logic       use1, use2, ex_we, ex_ld, mem_we, wb_we, br;

    logic [1:0]  a_f1, a_f2, b_f1, b_f2;
    logic        a_sf, a_sd, a_fd, a_fe, b_sf, b_sd, b_fd, b_fe;
    logic [15:0] a_scnt, a_fcnt;
    logic [3:0]  b_scnt, b_fcnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ex_hazard_controller #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(2), .CNT_W(16)) u_dut_a (
        .clk_i(clk), .reset_i(reset),
        .id_src1_i(src1), .id_src2_i(src2), .id_use1_i(use1), .id_use2_i(use2),
        .ex_reg_to_write_i(ex_dst), .ex_reg_we_i(ex_we), .ex_is_load_i(ex_ld),
        .mem_reg_to_write_i(mem_dst), .mem_reg_we_i(mem_we),
        .wb_reg_to_write_i(wb_dst), .wb_reg_we_i(wb_we), .branch_taken_i(br),
        .fwd_sel1_o(a_f1), .fwd_sel2_o(a_f2), .stall_fetch_o(a_sf), .stall_decode_o(a_sd),
        .flush_decode_o(a_fd), .flush_execute_o(a_fe),
        .stall_count_o(a_scnt), .flush_count_o(a_fcnt)
    );

    ex_hazard_controller #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(3), .CNT_W(4)) u_dut_b (
        .clk_i(clk), .reset_i(reset),
        .id_src1_i(src1), .id_src2_i(src2), .id_use1_i(use1), .id_use2_i(use2),
        .ex_reg_to_write_i(ex_dst), .ex_reg_we_i(ex_we), .ex_is_load_i(ex_ld),
        .mem_reg_to_write_i(mem_dst), .mem_reg_we_i(mem_we),
        .wb_reg_to_write_i(wb_dst), .wb_reg_we_i(wb_we), .branch_taken_i(br),
        .fwd_sel1_o(b_f1), .fwd_sel2_o(b_f2), .stall_fetch_o(b_sf), .stall_decode_o(b_sd),
        .flush_decode_o(b_fd), .flush_execute_o(b_fe),
        .stall_count_o(b_scnt), .flush_count_o(b_fcnt)
    );

    // Reference model: counts of bubbles/squash cycles still owed per instance.
    int p_lsc[2]  = '{1, 3};
    int p_fc[2]   = '{2, 3};
    int p_cmax[2] = '{65535, 15};
    int m_stall_left[2], m_flush_left[2], m_scnt[2], m_fcnt[2];

    typedef struct packed {
        logic [1:0] f1;
        logic [1:0] f2;
        logic       sf;
        logic       sd;
        logic       fd;
        logic       fe;
    } ctl_t;

    typedef struct {
        logic [3:0] s1, s2;
        logic       u1, u2;
        logic [3:0] exd;
        logic       exwe, exld;
        logic [3:0] memd;
        logic       memwe;
        logic [3:0] wbd;
        logic       wbwe;
        logic [1:0] f1, f2;
        logic       sf, fe;
    } vec_t;

    function automatic logic [1:0] ref_fwd(input logic rd, input logic [3:0] src);
        if (!rd || src == 4'd0) return 2'd0;
        if (ex_we && ex_dst == src && !ex_ld) return 2'd1;
        if (mem_we && mem_dst == src) return 2'd2;
        if (wb_we && wb_dst == src) return 2'd3;
        return 2'd0;
    endfunction

    function automatic bit ref_haz();
        bit hit1 = use1 && src1 != 0 && src1 == ex_dst;
        bit hit2 = use2 && src2 != 0 && src2 == ex_dst;
        return ex_ld && ex_we && (hit1 || hit2);
    endfunction

    function automatic ctl_t model_out(input int i);
        ctl_t e = '0;
        if (reset) return e;
        e.f1 = ref_fwd(use1, src1);
        e.f2 = ref_fwd(use2, src2);
        if (m_flush_left[i] > 0 || br) begin
            e.fd = 1'b1;
            e.fe = 1'b1;
        end else if (m_stall_left[i] > 0 || ref_haz()) begin
            e.sf = 1'b1;
            e.sd = 1'b1;
            e.fe = 1'b1;
        end
        return e;
    endfunction

    task automatic model_commit(input int i);
        if (reset) begin
            m_stall_left[i] = 0;
            m_flush_left[i] = 0;
            m_scnt[i]       = 0;
            m_fcnt[i]       = 0;
        end else if (m_flush_left[i] > 0) begin
            m_flush_left[i]--;
        end else if (br) begin
            if (m_fcnt[i] < p_cmax[i]) m_fcnt[i]++;
            m_flush_left[i] = p_fc[i] - 1;
            m_stall_left[i] = 0;
        end else if (m_stall_left[i] > 0 || ref_haz()) begin
            if (m_scnt[i] < p_cmax[i]) m_scnt[i]++;
            if (m_stall_left[i] > 0) m_stall_left[i]--;
            else m_stall_left[i] = p_lsc[i] - 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        ctl_t e, a;
        #1;
        for (int i = 0; i < 2; i++) begin
            e = model_out(i);
            a = (i == 0) ? {a_f1, a_f2, a_sf, a_sd, a_fd, a_fe}
                         : {b_f1, b_f2, b_sf, b_sd, b_fd, b_fe};
            chk($sformatf("dut%0d.fwdSel1", i), 32'(a.f1), 32'(e.f1));
            chk($sformatf("dut%0d.fwdSel2", i), 32'(a.f2), 32'(e.f2));
            chk($sformatf("dut%0d.stallFetch", i), 32'(a.sf), 32'(e.sf));
            chk($sformatf("dut%0d.stallDecode", i), 32'(a.sd), 32'(e.sd));
            chk($sformatf("dut%0d.flushDecode", i), 32'(a.fd), 32'(e.fd));
            chk($sformatf("dut%0d.flushExecute", i), 32'(a.fe), 32'(e.fe));
        end
        chk("dut0.stallCount", 32'(a_scnt), m_scnt[0]);
        chk("dut0.flushCount", 32'(a_fcnt), m_fcnt[0]);
        chk("dut1.stallCount", 32'(b_scnt), m_scnt[1]);
        chk("dut1.flushCount", 32'(b_fcnt), m_fcnt[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_commit(0);
        model_commit(1);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        reset = 1'b0; br = 1'b0;
        src1 = 4'd0; src2 = 4'd0; use1 = 1'b0; use2 = 1'b0;
        ex_dst = 4'd0; ex_we = 1'b0; ex_ld = 1'b0;
        mem_dst = 4'd0; mem_we = 1'b0; wb_dst = 4'd0; wb_we = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        check_model();
        tick();
        reset = 1'b0;
    endtask

    task automatic set_load5();
        ex_ld = 1'b1; ex_we = 1'b1; ex_dst = 4'd5; src1 = 4'd5; use1 = 1'b1;
    endtask

    vec_t tbl[8];

    initial begin
        // s1 s2 u1 u2 exd exwe exld memd memwe wbd wbwe | f1 f2 sf fe
        tbl[0] = '{4'd3, 4'd0, 1, 0, 4'd3, 1, 0, 4'd3, 1, 4'd0, 0, 2'd1, 2'd0, 0, 0};
        tbl[1] = '{4'd3, 4'd0, 1, 0, 4'd3, 0, 0, 4'd3, 1, 4'd0, 0, 2'd2, 2'd0, 0, 0};
        tbl[2] = '{4'd3, 4'd0, 1, 0, 4'd3, 0, 0, 4'd3, 0, 4'd3, 1, 2'd3, 2'd0, 0, 0};
        tbl[3] = '{4'd0, 4'd0, 0, 1, 4'd0, 1, 1, 4'd0, 0, 4'd0, 0, 2'd0, 2'd0, 0, 0};
        tbl[4] = '{4'd5, 4'd0, 1, 0, 4'd5, 1, 1, 4'd0, 0, 4'd0, 0, 2'd0, 2'd0, 1, 1};
        tbl[5] = '{4'd0, 4'd6, 0, 1, 4'd6, 1, 1, 4'd6, 1, 4'd0, 0, 2'd0, 2'd2, 1, 1};
        tbl[6] = '{4'd5, 4'd0, 0, 0, 4'd5, 1, 1, 4'd0, 0, 4'd0, 0, 2'd0, 2'd0, 0, 0};
        tbl[7] = '{4'd2, 4'd7, 1, 1, 4'd0, 0, 0, 4'd2, 1, 4'd7, 1, 2'd2, 2'd3, 0, 0};

        clear_inputs();
        @(negedge clk);
        do_reset();
        do_reset();

        foreach (tbl[k]) begin
            src1 = tbl[k].s1; src2 = tbl[k].s2; use1 = tbl[k].u1; use2 = tbl[k].u2;
            ex_dst = tbl[k].exd; ex_we = tbl[k].exwe; ex_ld = tbl[k].exld;
            mem_dst = tbl[k].memd; mem_we = tbl[k].memwe;
            wb_dst = tbl[k].wbd; wb_we = tbl[k].wbwe;
            check_model();
            chk($sformatf("vec%0d.fwdSel1", k), 32'(a_f1), 32'(tbl[k].f1));
            chk($sformatf("vec%0d.fwdSel2", k), 32'(a_f2), 32'(tbl[k].f2));
            chk($sformatf("vec%0d.stallFetch", k), 32'(a_sf), 32'(tbl[k].sf));
            chk($sformatf("vec%0d.flushExecute", k), 32'(a_fe), 32'(tbl[k].fe));
            tick();
        end

        // Load-use with a single bubble, then forwarding from MEM.
        do_reset();
        set_load5();
        check_model();
        chk("lu.stall", 32'({a_sf, a_sd, a_fe}), 32'(3'b111));
        tick();
        clear_inputs();
        src1 = 4'd5; use1 = 1'b1; mem_dst = 4'd5; mem_we = 1'b1;
        check_model();
        chk("lu.fwdMem", 32'(a_f1), 32'd2);
        chk("lu.stallGone", 32'(a_sf), 32'd0);
        chk("lu.stallCount", 32'(a_scnt), 32'd1);
        tick();

        // Two-cycle branch squash; a branch in the second cycle is ignored.
        do_reset();
        br = 1'b1;
        check_model();
        chk("br.c0", 32'({a_fd, a_fe}), 32'(2'b11));
        tick();
        check_model();
        chk("br.c1", 32'({a_fd, a_fe}), 32'(2'b11));
        tick();
        br = 1'b0;
        check_model();
        chk("br.c2", 32'({a_fd, a_fe}), 32'(2'b00));
        chk("br.flushCount", 32'(a_fcnt), 32'd1);
        tick();

        // Branch and load hazard together: branch wins.
        do_reset();
        set_load5();
        br = 1'b1;
        check_model();
        chk("brlu.stallFetch", 32'(a_sf), 32'd0);
        chk("brlu.flushDecode", 32'(a_fd), 32'd1);
        tick();
        clear_inputs();
        check_model();
        chk("brlu.stallCount", 32'(a_scnt), 32'd0);
        tick();

        // Branch arriving during LSTALL of the 3-bubble instance.
        do_reset();
        set_load5();
        check_model();
        tick();
        clear_inputs();
        br = 1'b1;
        check_model();
        chk("lsbr.flushDecode", 32'(b_fd), 32'd1);
        chk("lsbr.stallFetch", 32'(b_sf), 32'd0);
        tick();
        br = 1'b0;
        check_model();
        chk("lsbr.bflush", 32'({b_fd, b_sf}), 32'(2'b10));
        tick();

        // Reset during the first BFLUSH cycle.
        do_reset();
        br = 1'b1;
        check_model();
        tick();
        br = 1'b0;
        reset = 1'b1;
        check_model();
        chk("rst.outs", 32'({a_sf, a_sd, a_fd, a_fe}), 32'd0);
        tick();
        reset = 1'b0;
        check_model();
        chk("rst.run", 32'(a_fd), 32'd0);
        chk("rst.flushCount", 32'(a_fcnt), 32'd0);
        tick();

        // Counter saturation on the 4-bit instance.
        do_reset();
        set_load5();
        for (int c = 0; c < 20; c++) begin
            check_model();
            tick();
        end
        clear_inputs();
        check_model();
        chk("sat.b", 32'(b_scnt), 32'd15);
        chk("sat.a", 32'(a_scnt), 32'd20);
        tick();

        // Randomized traffic against the model.
        for (int c = 0; c < 2000; c++) begin
            reset   = ($urandom_range(0, 39) == 0);
            br      = ($urandom_range(0, 5) == 0);
            src1    = 4'($urandom_range(0, 3));
            src2    = 4'($urandom_range(0, 3));
            use1    = 1'($urandom_range(0, 1));
            use2    = 1'($urandom_range(0, 1));
            ex_dst  = 4'($urandom_range(0, 3));
            ex_we   = 1'($urandom_range(0, 1));
            ex_ld   = 1'($urandom_range(0, 1));
            mem_dst = 4'($urandom_range(0, 3));
            mem_we  = 1'($urandom_range(0, 1));
            wb_dst  = 4'($urandom_range(0, 3));
            wb_we   = 1'($urandom_range(0, 1));
            check_model();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_hazard_controller.md
Name: ex_hazard_controller

Overview:
- Sequences the 24-bit execute stage and the stages around it.
- Chooses operand-forwarding sources for the decode→execute operands.
- Inserts load-use stalls and squashes wrong-path instructions after a taken branch (pcWe).
- Sits beside the execute stage and drives the stall/flush enables of the IF/ID and ID/EX pipeline registers. Keeps saturating stall and flush counters for performance debug.

Parameters:
- LOAD_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..15).
- FLUSH_CYCLES, 2, cycles decode is squashed after a taken branch (1..15).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- idSrc1, idSrc2  in  4  source registers of the instruction in decode.
- idUse1, idUse2  in  1  the matching source is actually read.
- exRegToWrite  in  4  destination register of the instruction in execute.
- exRegWe  in  1  the execute instruction writes a register.
- exIsLoad  in  1  the execute instruction is a load (regWe=1, writeRegFromAlu=0).
- memRegToWrite  in  4  destination register in memory stage; memRegWe  in  1.
- wbRegToWrite  in  4  destination register in writeback; wbRegWe  in  1.
- branchTaken  in  1  execute is redirecting the PC this cycle (pcWe qualified).
- fwdSel1, fwdSel2  out  2  operand source: 00 regfile, 01 EX result, 10 MEM result, 11 WB data.
- stallFetch  out  1  hold PC and IF/ID.
- stallDecode  out  1  hold ID/EX inputs.
- flushDecode  out  1  clear IF/ID.
- flushExecute  out  1  clear ID/EX (bubble: all write enables 0).
- stallCount  out  CNT_W  cycles with stallDecode=1, saturating.
- flushCount  out  CNT_W  taken-branch events, saturating.

Behaviour:
- Reset (reset=1 at posedge): state←RUN, cnt←0, stallCount←0, flushCount←0.
- While reset is high, all stall/flush outputs are 0 and fwdSel=00, regardless of inputs.
- Register 0 is hardwired zero: it never matches for a hazard or forwarding.
- match(src, dst, we) = use & we & (src == dst) & (src != 0).
- Forwarding (combinational, per operand), highest priority first:
  - EX match with exIsLoad=0 → 01.
  - MEM match → 10.
  - WB match → 11.
  - Otherwise 00.
  - An EX match with exIsLoad=1 never selects 01.
- loadHaz = exIsLoad & (match1_EX | match2_EX).
- FSM states: RUN, LSTALL, BFLUSH. cnt is 4 bits.
- RUN:
  - If branchTaken: flushDecode=1, flushExecute=1, flushCount+1. If FLUSH_CYCLES>1, go BFLUSH with cnt=FLUSH_CYCLES-2; else stay in RUN.
  - Else if loadHaz: stallFetch=1, stallDecode=1, flushExecute=1. If LOAD_STALL_CYCLES>1, go LSTALL with cnt=LOAD_STALL_CYCLES-2; else stay in RUN.
  - Otherwise all four control outputs are 0.
  - branchTaken has priority over loadHaz: the stalled instruction is wrong-path.
- LSTALL:
  - stallFetch=1, stallDecode=1, flushExecute=1.
  - If branchTaken: behave as RUN's branch case (branch wins).
  - Else if cnt==0 → RUN; else cnt−1.
- BFLUSH:
  - flushDecode=1; flushExecute=1; stall outputs 0.
  - branchTaken is ignored (it comes from a squashed instruction).
  - loadHaz is ignored.
  - If cnt==0 → RUN; else cnt−1.
- Counters:
  - stallCount increments on every non-reset cycle with stallDecode=1.
  - flushCount increments once per accepted branch event.
  - Both hold at 2^CNT_W−1 (no wrap).
- Latency: control outputs are valid in the same cycle as their inputs. State updates at the next posedge.
- Reset asserted mid-stall or mid-flush aborts immediately to RUN on that edge.

Test Plan:
- Forwarding priority:
  - Setup: idSrc1=3, idUse1=1; exRegToWrite=3, exRegWe=1, exIsLoad=0; memRegToWrite=3, memRegWe=1.
  - Required: fwdSel1=01. Drop exRegWe → fwdSel1=10. Drop memRegWe with wbRegToWrite=3, wbRegWe=1 → 11.
- R0 exclusion:
  - Setup: idSrc2=0, exRegToWrite=0, exRegWe=1, exIsLoad=1.
  - Required: fwdSel2=00, no stall.
- Load-use, LOAD_STALL_CYCLES=1:
  - Setup: exIsLoad=1, exRegWe=1, exRegToWrite=5, idSrc1=5, idUse1=1 for one cycle.
  - Required: stallFetch=stallDecode=flushExecute=1 for exactly 1 cycle, stallCount=1.
  - Next cycle, with the load moved to MEM (memRegToWrite=5, memRegWe=1): fwdSel1=10.
- Branch flush, FLUSH_CYCLES=2:
  - Stimulus: 1-cycle branchTaken pulse.
  - Required: flushDecode=1 for 2 consecutive cycles, flushExecute=1 for the same 2 cycles, flushCount=1.
  - A branchTaken during the second cycle is ignored: flushCount stays 1 and the FSM is back in RUN after 2 cycles.
- Simultaneous branchTaken and loadHaz:
  - Required: flush only, with stallFetch=0 and stallCount unchanged.
  - Repeat with LOAD_STALL_CYCLES=3 and a branch arriving in LSTALL: transition to BFLUSH.
- Reset and saturation:
  - Assert reset in the first BFLUSH cycle → outputs 0 that cycle and state RUN afterwards.
  - With CNT_W=4, hold a load hazard for 20 cycles → stallCount=15.
